// File: rtl/voice_allocator.sv
// Voice allocator: accepts MIDI note-on/note-off events and maps each one to a
// voice slot. Every accepted event triggers a sequential scan of all voices,
// one voice per cycle. The scan looks for two things: a voice already holding
// the note (match) and an idle voice (free). A one-cycle ISSUE strobe then
// reports the chosen target to the voice controller.
//
// Ports:
//   clk, reset             - system clock, asynchronous active-high reset
//   in_valid / in_ready    - event handshake (ready only while idle)
//   in_note_status         - 1 = note-on, 0 = note-off
//   in_midi_note           - 7-bit MIDI note number
//   in_velocity            - 7-bit velocity; a note-on at velocity 0 is a note-off
//   out_valid              - one-cycle strobe, no backpressure
//   out_note_status        - 1 = start voice, 0 = release voice
//   out_voice_index        - target voice, zero-extended to 8 bits
//   out_midi_note          - event note payload (held between strobes)
//   out_velocity           - event velocity payload (held between strobes)
//   active_mask            - bit i set while voice i holds a note
module voice_allocator #(
  parameter int NUM_VOICES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_note_status,
  input  logic [6:0]            in_midi_note,
  input  logic [6:0]            in_velocity,
  output logic                  out_valid,
  output logic                  out_note_status,
  output logic [7:0]            out_voice_index,
  output logic [6:0]            out_midi_note,
  output logic [6:0]            out_velocity,
  output logic [NUM_VOICES-1:0] active_mask
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   scan_idx, match_idx, free_idx, steal_ptr;
  logic            have_match, have_free;
  logic            lat_on;
  logic [6:0]      lat_note, lat_vel;
  logic [6:0]      notes [NUM_VOICES];

  logic            last_scan, match_hit, free_hit, m_found, f_found;
  logic [IW-1:0]   m_idx, f_idx, target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SCAN;
      end
      SCAN:    if (scan_idx == LAST) state_next = ISSUE;
      ISSUE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The voice under examination in this cycle is folded in combinationally,
  // so the decision on the final scan cycle already includes the last voice.
  always_comb begin
    last_scan = (state == SCAN) && (scan_idx == LAST);
    match_hit = active_mask[scan_idx] && (notes[scan_idx] == lat_note);
    free_hit  = !active_mask[scan_idx];
    m_found   = have_match || match_hit;
    f_found   = have_free || free_hit;
    m_idx     = have_match ? match_idx : scan_idx;
    f_idx     = have_free ? free_idx : scan_idx;
    if (m_found)      target = m_idx;
    else if (f_found) target = f_idx;
    else              target = steal_ptr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_note_status <= 1'b0;
      out_voice_index <= '0;
      out_midi_note   <= '0;
      out_velocity    <= '0;
      active_mask     <= '0;
      steal_ptr       <= '0;
      scan_idx        <= '0;
      match_idx       <= '0;
      free_idx        <= '0;
      have_match      <= 1'b0;
      have_free       <= 1'b0;
      lat_on          <= 1'b0;
      lat_note        <= '0;
      lat_vel         <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) notes[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE && in_valid) begin
        lat_on     <= in_note_status && (in_velocity != 7'd0);
        lat_note   <= in_midi_note;
        lat_vel    <= in_velocity;
        scan_idx   <= '0;
        have_match <= 1'b0;
        have_free  <= 1'b0;
      end
      if (state == SCAN) begin
        scan_idx <= scan_idx + IW'(1);
        if (!have_match && match_hit) begin
          have_match <= 1'b1;
          match_idx  <= scan_idx;
        end
        if (!have_free && free_hit) begin
          have_free <= 1'b1;
          free_idx  <= scan_idx;
        end
      end
      if (last_scan && (lat_on || m_found)) begin
        out_valid       <= 1'b1;
        out_note_status <= lat_on;
        out_voice_index <= {{(8 - IW){1'b0}}, (lat_on ? target : m_idx)};
        out_midi_note   <= lat_note;
        out_velocity    <= lat_vel;
        if (lat_on) begin
          active_mask[target] <= 1'b1;
          notes[target]       <= lat_note;
          if (!m_found && !f_found)
            steal_ptr <= (steal_ptr == LAST) ? '0 : steal_ptr + IW'(1);
        end else begin
          active_mask[m_idx] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator (NUM_VOICES = 8). The stimulus process pushes the
// expected strobe (cycle, payload, mask) for each event into a queue. The
// monitor pops an entry and compares it whenever out_valid is seen.
module tb_voice_allocator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_note_status = 1'b0;
  logic [6:0] in_midi_note = '0;
  logic [6:0] in_velocity = '0;
  logic       out_valid;
  logic       out_note_status;
  logic [7:0] out_voice_index;
  logic [6:0] out_midi_note;
  logic [6:0] out_velocity;
  logic [7:0] active_mask;

  voice_allocator #(.NUM_VOICES(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_note_status  (in_note_status),
    .in_midi_note    (in_midi_note),
    .in_velocity     (in_velocity),
    .out_valid       (out_valid),
    .out_note_status (out_note_status),
    .out_voice_index (out_voice_index),
    .out_midi_note   (out_midi_note),
    .out_velocity    (out_velocity),
    .active_mask     (active_mask)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    bit          st;
    bit [7:0]    idx;
    bit [6:0]    note;
    bit [6:0]    vel;
    bit [7:0]    mask;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, int unsigned act, int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual 1 required 0 (cycle %0d idx %0d)", cyc, out_voice_index);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_cycle",  cyc, e.cyc);
        chk("out_status", out_note_status, e.st);
        chk("out_index",  out_voice_index, e.idx);
        chk("out_note",   out_midi_note, e.note);
        chk("out_vel",    out_velocity, e.vel);
        chk("out_mask",   active_mask, e.mask);
      end
    end
  end

  // Waits for in_ready, issues one event, and checks the return to idle at T+10.
  // If busy_poke is set, a stray in_valid is driven mid-scan and must be ignored.
  task automatic send(input bit st, input bit [6:0] note, input bit [6:0] vel,
                      input bit exp_out, input bit exp_st, input bit [7:0] idx,
                      input bit [7:0] mask, input bit busy_poke);
    int unsigned c;
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    c = cyc;
    in_valid = 1'b1;
    in_note_status = st;
    in_midi_note = note;
    in_velocity = vel;
    if (exp_out) begin
      e.cyc = c + 9; e.st = exp_st; e.idx = idx; e.note = note; e.vel = vel; e.mask = mask;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("ready_low_in_scan", in_ready, 0);
    if (busy_poke) begin
      repeat (2) @(negedge clk);
      in_valid = 1'b1;
      in_note_status = 1'b1;
      in_midi_note = 7'd5;
      in_velocity = 7'd9;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
    end else begin
      repeat (9) @(negedge clk);
    end
    chk("ready_at_T10", in_ready, 1);
    chk("mask_after", active_mask, mask);
    chk("out_valid_low_after", out_valid, 0);
    if (exp_out) chk("payload_hold", out_voice_index, idx);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int unsigned c;
    // Reset state, sampled while reset is high and again after release.
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mask", active_mask, 0);
    chk("rst_index", out_voice_index, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_mask", active_mask, 0);

    // First note-on, then fill, then two steals and a third to show steal_ptr = 2.
    send(1, 7'd60, 7'd100, 1, 1, 8'd0, 8'h01, 0);
    send(1, 7'd61, 7'd100, 1, 1, 8'd1, 8'h03, 0);
    send(1, 7'd62, 7'd100, 1, 1, 8'd2, 8'h07, 0);
    send(1, 7'd63, 7'd100, 1, 1, 8'd3, 8'h0F, 0);
    send(1, 7'd64, 7'd100, 1, 1, 8'd4, 8'h1F, 0);
    send(1, 7'd65, 7'd100, 1, 1, 8'd5, 8'h3F, 0);
    send(1, 7'd66, 7'd100, 1, 1, 8'd6, 8'h7F, 0);
    send(1, 7'd67, 7'd100, 1, 1, 8'd7, 8'hFF, 0);
    send(1, 7'd70, 7'd80,  1, 1, 8'd0, 8'hFF, 0);
    send(1, 7'd71, 7'd80,  1, 1, 8'd1, 8'hFF, 0);
    send(1, 7'd72, 7'd80,  1, 1, 8'd2, 8'hFF, 0);

    // Fresh fill, note-off with and without match, then a free slot beats stealing.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bit [7:0] m;
      m = 8'((16'd1 << (i + 1)) - 16'd1);
      send(1, 7'(60 + i), 7'd90, 1, 1, 8'(i), m, 0);
    end
    send(0, 7'd62, 7'd64, 1, 0, 8'd2, 8'hFB, 0);
    send(0, 7'd99, 7'd64, 0, 0, 8'd0, 8'hFB, 0);
    send(1, 7'd90, 7'd33, 1, 1, 8'd2, 8'hFF, 0);

    // Velocity-0 note-on acts as note-off; retrigger of a held note; stray in_valid ignored.
    send(1, 7'd61, 7'd0,  1, 0, 8'd1, 8'hFD, 1);
    send(1, 7'd60, 7'd50, 1, 1, 8'd0, 8'hFD, 0);

    // Reset in the middle of a scan aborts the event.
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    c = cyc;
    in_valid = 1'b1;
    in_note_status = 1'b1;
    in_midi_note = 7'd77;
    in_velocity = 7'd40;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_mask", active_mask, 0);
    repeat (8) @(negedge clk);
    chk("abort_mask_late", active_mask, 0);
    chk("abort_ready", in_ready, 1);
    send(1, 7'd80, 7'd20, 1, 1, 8'd0, 8'h01, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
